// File: rtl/power_stat_pkg.sv
// Shared types and constants for the power statistics monitor.
package power_stat_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned LED_BAR_W  = 7;

  typedef enum logic {
    NORMAL = 1'b0,
    ALARM  = 1'b1
  } alert_state_e;

endpackage

// File: rtl/power_sample_ring.sv
// Sample ring buffer: synchronous write, combinational read of the slot about to be overwritten.
module power_sample_ring #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LOG2_DEPTH = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] old_data_c_o
);

  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr_q;
  logic [LOG2_DEPTH-1:0] wr_ptr_d;

  assign wr_ptr_d     = wr_en_i ? wr_ptr_q + LOG2_DEPTH'(1) : wr_ptr_q;
  assign old_data_c_o = mem_q[wr_ptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage is deliberately unreset; fill gating in the consumer masks stale slots.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/power_stat_monitor.sv
// Moving average, hysteresis alert and LED bar graph for power-monitor readings.
// Optional peak-hold with timed decay is enabled by defining PWR_PEAK_HOLD_EN.
module power_stat_monitor
  import power_stat_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned LOG2_DEPTH  = 3,
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic              CLK_50,
  input  logic              RESET,
  input  logic              SAMPLE_VALID,
  input  logic [DATA_W-1:0] SAMPLE,
  input  logic [DATA_W-1:0] ALERT_HI,
  input  logic [DATA_W-1:0] ALERT_LO,
  output logic [DATA_W-1:0] AVG,
  output logic              AVG_VALID,
  output logic [DATA_W-1:0] PEAK,
  output logic              ALERT,
  output logic [7:0]        LED
);

  localparam int unsigned SUM_W  = DATA_W + LOG2_DEPTH;
  localparam int unsigned FILL_W = LOG2_DEPTH + 1;
  localparam int unsigned DEPTH  = 1 << LOG2_DEPTH;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  if (LOG2_DEPTH < 1 || LOG2_DEPTH > 6 || HOLD_CYCLES < 1 || DATA_W < 3) begin : g_cfg_err
    $error("power_stat_monitor: unsupported parameter set");
  end

  logic [DATA_W-1:0] old_data;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] avg_q, avg_d;
  logic              avg_valid_q, avg_valid_d;
  alert_state_e      state_q, state_d;
  logic [7:0]        led_q, led_d;
  logic [2:0]        bar_k;
  logic              full;

  power_sample_ring #(
    .DATA_W     (DATA_W),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_ring (
    .clk_i        (CLK_50),
    .rst_i        (RESET),
    .wr_en_i      (SAMPLE_VALID),
    .wr_data_i    (SAMPLE),
    .old_data_c_o (old_data)
  );

  assign full  = (fill_q == FILL_MAX);
  assign bar_k = avg_q[DATA_W-1 -: 3];

  // Running sum, fill level and average pipeline.
  always_comb begin
    sum_d       = sum_q;
    fill_d      = fill_q;
    avg_d       = sum_q[SUM_W-1:LOG2_DEPTH];
    avg_valid_d = full;
    if (SAMPLE_VALID) begin
      sum_d = sum_q + SUM_W'(SAMPLE) - (full ? SUM_W'(old_data) : '0);
      if (!full) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  // Alert FSM next state and LED image.
  always_comb begin
    state_d = state_q;
    led_d   = 8'hFF;
    case (state_q)
      NORMAL: if (avg_valid_q && (avg_q > ALERT_HI)) state_d = ALARM;
      ALARM:  if (avg_q < ALERT_LO)                  state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
    for (int unsigned i = 0; i < LED_BAR_W; i++) begin
      led_d[i] = ~(avg_valid_q && (3'(i) < bar_k));
    end
    led_d[7] = ~(state_d == ALARM);
  end

  always_ff @(posedge CLK_50 or posedge RESET) begin
    if (RESET) begin
      sum_q       <= '0;
      fill_q      <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      state_q     <= NORMAL;
      led_q       <= 8'hFF;
    end else begin
      sum_q       <= sum_d;
      fill_q      <= fill_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      state_q     <= state_d;
      led_q       <= led_d;
    end
  end

`ifdef PWR_PEAK_HOLD_EN
  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);

  logic [DATA_W-1:0] peak_q, peak_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;

  // A new maximum wins over decay even in the expiry cycle.
  always_comb begin
    peak_d     = peak_q;
    hold_cnt_d = hold_cnt_q;
    if (SAMPLE_VALID && (SAMPLE > peak_q)) begin
      peak_d     = SAMPLE;
      hold_cnt_d = HOLD_RELOAD;
    end else if (hold_cnt_q == '0) begin
      peak_d     = avg_q;
      hold_cnt_d = HOLD_RELOAD;
    end else begin
      hold_cnt_d = hold_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK_50 or posedge RESET) begin
    if (RESET) begin
      peak_q     <= '0;
      hold_cnt_q <= '0;
    end else begin
      peak_q     <= peak_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign PEAK = peak_q;
`else
  assign PEAK = '0;
`endif

  assign AVG       = avg_q;
  assign AVG_VALID = avg_valid_q;
  assign ALERT     = (state_q == ALARM);
  assign LED       = led_q;

endmodule

// File: tb/tb_power_stat_monitor.sv
// Directed bench for power_stat_monitor (DATA_W=16, LOG2_DEPTH=3, HOLD_CYCLES=100).
module tb_power_stat_monitor;

  logic        CLK_50;
  logic        RESET;
  logic        SAMPLE_VALID;
  logic [15:0] SAMPLE;
  logic [15:0] ALERT_HI;
  logic [15:0] ALERT_LO;
  logic [15:0] AVG;
  logic        AVG_VALID;
  logic [15:0] PEAK;
  logic        ALERT;
  logic [7:0]  LED;

  int total = 0;
  int bad   = 0;

  power_stat_monitor #(
    .DATA_W      (16),
    .LOG2_DEPTH  (3),
    .HOLD_CYCLES (100)
  ) dut (
    .CLK_50       (CLK_50),
    .RESET        (RESET),
    .SAMPLE_VALID (SAMPLE_VALID),
    .SAMPLE       (SAMPLE),
    .ALERT_HI     (ALERT_HI),
    .ALERT_LO     (ALERT_LO),
    .AVG          (AVG),
    .AVG_VALID    (AVG_VALID),
    .PEAK         (PEAK),
    .ALERT        (ALERT),
    .LED          (LED)
  );

  initial CLK_50 = 1'b0;
  always #5 CLK_50 = ~CLK_50;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Drive one cycle of stimulus, then sample 1 ns after the edge.
  task automatic cyc(input logic v, input logic [15:0] s);
    SAMPLE_VALID = v;
    SAMPLE       = s;
    @(posedge CLK_50);
    #1;
    SAMPLE_VALID = 1'b0;
  endtask

  task automatic stream(input logic [15:0] s, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, s);
  endtask

  logic [15:0] peak_hi_exp;
  logic [15:0] peak_decay_exp;

  initial begin
`ifdef PWR_PEAK_HOLD_EN
    peak_hi_exp    = 16'd40000;
    peak_decay_exp = 16'd5875;
`else
    peak_hi_exp    = 16'd0;
    peak_decay_exp = 16'd0;
`endif
    RESET        = 1'b1;
    SAMPLE_VALID = 1'b0;
    SAMPLE       = '0;
    ALERT_HI     = 16'hFFFF;
    ALERT_LO     = 16'd0;
    repeat (3) @(posedge CLK_50);
    #1;
    check_eq("rst_avg", AVG, 0);
    check_eq("rst_avg_valid", AVG_VALID, 0);
    check_eq("rst_peak", PEAK, 0);
    check_eq("rst_alert", ALERT, 0);
    check_eq("rst_led", LED, 8'hFF);
    RESET = 1'b0;

    // Fill: valid only after the eighth sample
    stream(16'd1000, 7);
    cyc(1'b0, '0);
    cyc(1'b0, '0);
    check_eq("fill7_valid", AVG_VALID, 0);
    cyc(1'b1, 16'd1000);
    cyc(1'b0, '0);
    check_eq("fill8_valid", AVG_VALID, 1);
    check_eq("fill8_avg", AVG, 1000);

    // Slide: AVG of sample j-1 visible after strobe j
    for (int j = 1; j <= 8; j++) begin
      cyc(1'b1, 16'd2000);
      if (j >= 2) check_eq("slide_avg", AVG, 32'(1000 + 125 * (j - 1)));
    end
    cyc(1'b0, '0);
    check_eq("slide_final", AVG, 2000);
    cyc(1'b0, '0);
    check_eq("slide_led", LED, 8'hFF);

    // Hysteresis
    ALERT_HI = 16'd3000;
    ALERT_LO = 16'd2000;
    for (int j = 1; j <= 8; j++) begin
      cyc(1'b1, 16'd3500);
      if (j == 7) begin
        check_eq("hys_avg_cross", AVG, 3125);
        check_eq("hys_alert_lag", ALERT, 0);
      end
      if (j == 8) begin
        check_eq("hys_alert_set", ALERT, 1);
        check_eq("hys_led7_set", LED[7], 0);
      end
    end
    cyc(1'b0, '0);
    cyc(1'b0, '0);
    check_eq("hys_avg3500", AVG, 3500);
    check_eq("hys_alert3500", ALERT, 1);
    stream(16'd2500, 8);
    cyc(1'b0, '0);
    cyc(1'b0, '0);
    check_eq("hys_avg2500", AVG, 2500);
    check_eq("hys_hold2500", ALERT, 1);
    for (int j = 1; j <= 8; j++) begin
      cyc(1'b1, 16'd1500);
      if (j == 5) check_eq("hys_avg_eq_lo", AVG, 2000);
      if (j == 6) begin
        check_eq("hys_avg1875", AVG, 1875);
        check_eq("hys_hold_eq_lo", ALERT, 1);
      end
      if (j == 7) begin
        check_eq("hys_alert_clr", ALERT, 0);
        check_eq("hys_led7_clr", LED[7], 1);
      end
    end
    cyc(1'b0, '0);
    cyc(1'b0, '0);
    check_eq("hys_avg1500", AVG, 1500);
    check_eq("hys_alert1500", ALERT, 0);

    // Bar graph, plus equality at ALERT_HI not triggering
    ALERT_HI = 16'hFFFF;
    stream(16'hA000, 8);
    cyc(1'b0, '0);
    cyc(1'b0, '0);
    check_eq("bar_avg", AVG, 16'hA000);
    check_eq("bar_led", LED, 8'hE0);
    check_eq("bar_alert", ALERT, 0);
`ifndef PWR_PEAK_HOLD_EN
    check_eq("bar_peak_off", PEAK, 0);
`endif
    ALERT_HI = 16'hA000;
    cyc(1'b0, '0);
    check_eq("hi_equal_alert", ALERT, 0);
    ALERT_HI = 16'h9FFF;
    cyc(1'b0, '0);
    check_eq("hi_above_alert", ALERT, 1);
    check_eq("hi_above_led", LED, 8'h60);

    // Asynchronous reset mid-stream
    cyc(1'b1, 16'd5000);
    cyc(1'b1, 16'd5000);
    RESET = 1'b1;
    #1;
    check_eq("mid_rst_avg", AVG, 0);
    check_eq("mid_rst_valid", AVG_VALID, 0);
    check_eq("mid_rst_peak", PEAK, 0);
    check_eq("mid_rst_alert", ALERT, 0);
    check_eq("mid_rst_led", LED, 8'hFF);
    cyc(1'b0, '0);
    RESET = 1'b0;
    cyc(1'b1, 16'd800);
    cyc(1'b0, '0);
    check_eq("refill_avg", AVG, 100);
    check_eq("refill_valid", AVG_VALID, 0);
    stream(16'd800, 7);
    cyc(1'b0, '0);
    check_eq("refill_full_avg", AVG, 800);
    check_eq("refill_full_valid", AVG_VALID, 1);

    // Peak capture, hold and decay to the average
    stream(16'd1000, 8);
    cyc(1'b1, 16'd40000);
    check_eq("peak_capture", PEAK, 32'(peak_hi_exp));
    repeat (99) cyc(1'b0, '0);
    check_eq("peak_held", PEAK, 32'(peak_hi_exp));
    cyc(1'b0, '0);
    check_eq("peak_avg", AVG, 5875);
    check_eq("peak_decay", PEAK, 32'(peak_decay_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/power_stat_monitor.md
# power_stat_monitor

Downstream consumer of the power-monitor controller. It takes each new 16-bit reading (Power, Current or Bus_Voltage register value) together with a one-cycle strobe. It keeps a 2^LOG2_DEPTH-sample moving average, raises an alert with hysteresis against programmable limits, and drives the board's eight active-low LEDs as a bar graph plus an alert indicator. An optional peak-hold register with timed decay is available.

## Interface
- DATA_W, 16: sample width; unsigned register LSBs
- LOG2_DEPTH, 3: log2 of averaging window depth (1..6)
- HOLD_CYCLES, 50_000_000: peak-hold time in clocks (1 s at 50 MHz)

- CLK_50  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- SAMPLE_VALID  in  1  one-cycle strobe, new reading present on SAMPLE
- SAMPLE  in  DATA_W  reading from power-monitor controller
- ALERT_HI  in  DATA_W  alert assert threshold (strictly greater)
- ALERT_LO  in  DATA_W  alert release threshold (strictly less)
- AVG  out  DATA_W  window average
- AVG_VALID  out  1  window has been filled since reset
- PEAK  out  DATA_W  held peak sample
- ALERT  out  1  hysteresis alert, active-high
- LED  out  8  active-low; LED[6:0] bar graph, LED[7] alert

## Operation
- **Ring buffer.** SAMPLE_VALID writes SAMPLE at wr_ptr. wr_ptr increments modulo 2^LOG2_DEPTH. The old entry at wr_ptr is read before the write.
- **Running sum.** Width DATA_W+LOG2_DEPTH, so it cannot overflow. Update rule: sum <= sum + SAMPLE − (full ? old : 0).
- **Fill count.** Saturates at 2^LOG2_DEPTH; `full` is true at saturation. The buffer array is never reset; fill gating makes its stale contents irrelevant.
- **Average.** AVG = sum >> LOG2_DEPTH (truncating) and is updated every cycle. AVG_VALID is a registered copy of `full`.
- **Alert FSM.**
  - States: NORMAL (reset state), ALARM.
  - NORMAL→ALARM when AVG_VALID && AVG > ALERT_HI.
  - ALARM→NORMAL when AVG < ALERT_LO.
  - ALERT = (state==ALARM).
  - If ALERT_LO > ALERT_HI, the rules are applied literally; no special handling.
- **LED bar.**
  - k = AVG[DATA_W−1:DATA_W−3], range 0..7.
  - Bar: LED[i] = ~(AVG_VALID && i < k) for i = 0..6.
  - Alert indicator: LED[7] = ~ALERT.
- **Reset (any cycle, including mid-window).** Clears wr_ptr, sum, fill, AVG=0, AVG_VALID=0, PEAK=0, ALERT=0, state NORMAL, LED=8'hFF, hold counter=0. Fill restarts from empty.
- **Back-to-back strobes.** SAMPLE_VALID may be high every cycle; every strobe is accepted. There is no backpressure.

## Timing
- SAMPLE_VALID at cycle t: buffer, wr_ptr, fill and sum update on edge t+1.
- AVG and AVG_VALID reflect that sample at edge t+2.
- ALERT, FSM and LED reflect it at edge t+3.
- PEAK updates at edge t+1.
- Throughput: one sample per clock.

## Configuration
- **With PWR_PEAK_HOLD_EN:**
  - On SAMPLE_VALID with SAMPLE > PEAK: PEAK <= SAMPLE and the hold counter reloads to HOLD_CYCLES−1.
  - Otherwise the counter decrements toward 0. In the cycle it is 0, PEAK <= AVG and the counter reloads.
  - If a larger sample arrives in the expiry cycle, the sample takes priority.
- **Without PWR_PEAK_HOLD_EN:** PEAK is held at 0 and no counter logic is generated.

## Structure
- **Package power_stat_pkg:** alert state enum (NORMAL, ALARM), default DATA_W, and the LED bar width constant (7).
- **Sub-module power_sample_ring:**
  - 2^LOG2_DEPTH × DATA_W storage.
  - Synchronous write, asynchronous read at the write address, giving read-before-write.
  - Owns wr_ptr.

## Test plan
- **Reset:** assert RESET mid-stream → same cycle AVG=0, AVG_VALID=0, PEAK=0, ALERT=0, LED=8'hFF; next strobe restarts fill.
- **Fill:** 8 strobes of SAMPLE=1000 (LOG2_DEPTH=3) → AVG_VALID stays 0 after 7 strobes; AVG_VALID=1 and AVG=1000 two cycles after the 8th.
- **Window slide:** after fill, back-to-back strobes of 2000 → AVG=1125, 1250 … 1500 after the 4th, 2000 after the 8th.
- **Hysteresis:** ALERT_HI=3000, ALERT_LO=2000.
  - Window averaging 3500 → ALERT=1 and LED[7]=0 one cycle after AVG.
  - Window at 2500 → ALERT stays 1.
  - Window at 1500 → ALERT=0.
- **Bar graph:** filled window of 16'hA000 (k=5), no alert → LED=8'hE0.
- **Peak hold** (PWR_PEAK_HOLD_EN, HOLD_CYCLES=100): stream of 1000 with one 40000 → PEAK=40000 next cycle; held 100 cycles, then PEAK=AVG. Without the macro, PEAK=0 throughout.
